// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with stall, flush and per-instruction valid.
// Instruction path either passes a synchronous memory's output through a stall hold buffer or registers it locally.
module if_id_stage_reg #(
  parameter int unsigned       XLEN        = 32,
  parameter int unsigned       ILEN        = 32,
  parameter bit                INSTR_REG   = 1'b0,
  parameter logic [ILEN-1:0]   NOP         = 32'h00000013,
  parameter logic [XLEN-1:0]   RESET_PC    = '0,
  parameter int unsigned       STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   if_valid,
  input  logic [XLEN-1:0]        if_pc,
  input  logic [ILEN-1:0]        if_instruction,
  output logic                   id_valid,
  output logic [XLEN-1:0]        id_pc,
  output logic [XLEN-1:0]        id_pc4,
  output logic [ILEN-1:0]        id_instruction,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {StPass, StHold} hold_st_e;

  localparam logic [XLEN-1:0]        PcStep = XLEN'(4);
  localparam logic [STALL_CNT_W-1:0] CntMax = '1;
  localparam logic [STALL_CNT_W-1:0] CntOne = STALL_CNT_W'(1);

  logic                   valid_q, valid_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        pc4_q, pc4_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  // Flush wins over stall; flush leaves the PC fields untouched.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (stall) begin
      if (cnt_q != CntMax) cnt_d = cnt_q + CntOne;
    end else begin
      valid_d = if_valid;
      pc_d    = if_pc;
      pc4_d   = if_pc + PcStep;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + PcStep;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_valid  = valid_q;
  assign id_pc     = pc_q;
  assign id_pc4    = pc4_q;
  assign stall_cnt = cnt_q;

  if (INSTR_REG) begin : g_instr_reg
    logic [ILEN-1:0] instr_q, instr_d;

    always_comb begin
      instr_d = instr_q;
      if (flush)       instr_d = NOP;
      else if (!stall) instr_d = if_instruction;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) instr_q <= NOP;
      else        instr_q <= instr_d;
    end

    assign id_instruction = valid_q ? instr_q : NOP;
  end else begin : g_hold_buf
    hold_st_e        st_q, st_d;
    logic [ILEN-1:0] hold_q, hold_d;

    // Capture the memory word only on the first stalled edge; later edges keep it.
    always_comb begin
      st_d   = st_q;
      hold_d = hold_q;
      if (flush || !stall) begin
        st_d   = StPass;
        hold_d = NOP;
      end else if (st_q == StPass) begin
        st_d   = StHold;
        hold_d = if_instruction;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= StPass;
        hold_q <= NOP;
      end else begin
        st_q   <= st_d;
        hold_q <= hold_d;
      end
    end

    assign id_instruction = !valid_q ? NOP : ((st_q == StHold) ? hold_q : if_instruction);
  end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Self-checking bench for if_id_stage_reg: both instruction modes plus a narrow-counter instance.
module tb_if_id_stage_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, if_valid;
  logic [31:0] if_pc, instr0, instr1;

  logic        v0, v1, vs;
  logic [31:0] pc0, pc40, ins0, pc1, pc41, ins1, pcs, pc4s, inss;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnts;

  int checks = 0;
  int passed = 0;

  // Reference model: ID contents as the pipeline rules describe them.
  logic        m_valid, m_frozen;
  logic [31:0] m_pc, m_instr1, m_snap0;
  int          m_n;

  if_id_stage_reg #(.INSTR_REG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .if_valid(if_valid),
    .if_pc(if_pc), .if_instruction(instr0), .id_valid(v0), .id_pc(pc0), .id_pc4(pc40),
    .id_instruction(ins0), .stall_cnt(cnt0)
  );

  if_id_stage_reg #(.INSTR_REG(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .if_valid(if_valid),
    .if_pc(if_pc), .if_instruction(instr1), .id_valid(v1), .id_pc(pc1), .id_pc4(pc41),
    .id_instruction(ins1), .stall_cnt(cnt1)
  );

  if_id_stage_reg #(.INSTR_REG(1'b0), .STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .if_valid(if_valid),
    .if_pc(if_pc), .if_instruction(instr0), .id_valid(vs), .id_pc(pcs), .id_pc4(pc4s),
    .id_instruction(inss), .stall_cnt(cnts)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] pc);
    return (pc * 32'h00010001) ^ 32'h0BADF00D;
  endfunction

  // Pass-through mode: decode sees the live memory word unless a stall froze it.
  function automatic logic [31:0] exp_ins0();
    return m_frozen ? m_snap0 : (m_valid ? instr0 : NOP);
  endfunction

  function automatic logic [31:0] exp_ins1();
    return m_valid ? m_instr1 : NOP;
  endfunction

  function automatic logic [15:0] exp_cnt16();
    return (m_n > 65535) ? 16'hFFFF : 16'(m_n);
  endfunction

  function automatic logic [3:0] exp_cnt4();
    return (m_n > 15) ? 4'hF : 4'(m_n);
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_frozen = 1'b0;
    m_pc     = 32'h0;
    m_instr1 = NOP;
    m_snap0  = NOP;
    m_n      = 0;
  endtask

  task automatic tick();
    logic [31:0] snap;
    snap = exp_ins0();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      m_valid  = 1'b0;
      m_frozen = 1'b0;
      m_instr1 = NOP;
    end else if (stall) begin
      m_snap0  = snap;
      m_frozen = 1'b1;
      m_n++;
    end else begin
      m_valid  = if_valid;
      m_pc     = if_pc;
      m_instr1 = instr1;
      m_frozen = 1'b0;
    end
    #2;
  endtask

  task automatic test_reset();
    stall = 1'b0; flush = 1'b0; if_valid = 1'b1;
    if_pc = 32'h40; instr1 = word(32'h40); instr0 = 32'h0;
    tick();
    stall = 1'b1; instr0 = word(32'h40);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (v0 !== 1'b0) $display("FAIL reset_valid got %0b want 0", v0); else passed++;
    checks++; if (pc0 !== 32'h0) $display("FAIL reset_pc got %h want 0", pc0); else passed++;
    checks++; if (pc40 !== 32'h4) $display("FAIL reset_pc4 got %h want 4", pc40); else passed++;
    checks++; if (ins0 !== NOP) $display("FAIL reset_instr0 got %h want %h", ins0, NOP); else passed++;
    checks++; if (ins1 !== NOP) $display("FAIL reset_instr1 got %h want %h", ins1, NOP); else passed++;
    checks++; if (cnt0 !== 16'h0) $display("FAIL reset_cnt got %0d want 0", cnt0); else passed++;
    model_reset();
    tick();
    rst_n = 1'b1; stall = 1'b0;
    #1;
    checks++; if (cnt0 !== 16'h0) $display("FAIL post_reset_cnt got %0d want 0", cnt0); else passed++;
    checks++; if (ins0 !== NOP) $display("FAIL post_reset_instr got %h want %h", ins0, NOP); else passed++;
  endtask

  task automatic test_streaming();
    logic [31:0] prev;
    stall = 1'b0; flush = 1'b0; if_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prev   = 32'h100 + 32'(4 * (i - 1));
      if_pc  = 32'h100 + 32'(4 * i);
      instr1 = word(if_pc);
      instr0 = (i == 0) ? 32'h0 : word(prev);
      #1;
      if (i > 0) begin
        checks++; if (pc0 !== prev) $display("FAIL stream_pc0 got %h want %h", pc0, prev); else passed++;
        checks++; if (pc40 !== prev + 32'd4) $display("FAIL stream_pc4 got %h want %h", pc40, prev + 32'd4); else passed++;
        checks++; if (ins0 !== word(prev)) $display("FAIL stream_instr0 got %h want %h", ins0, word(prev)); else passed++;
        checks++; if (pc1 !== prev) $display("FAIL stream_pc1 got %h want %h", pc1, prev); else passed++;
        checks++; if (ins1 !== word(prev)) $display("FAIL stream_instr1 got %h want %h", ins1, word(prev)); else passed++;
        checks++; if (v0 !== 1'b1) $display("FAIL stream_valid got %0b want 1", v0); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_stall_hold();
    stall = 1'b0; flush = 1'b0; if_valid = 1'b1;
    if_pc = 32'h200; instr1 = word(32'h200); instr0 = 32'h0;
    tick();
    if_pc = 32'h204; instr1 = word(32'h204); instr0 = 32'h00A00093;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) instr0 = 32'hDEADBEEF;
      stall = (k < 3);
      #1;
      checks++; if (ins0 !== 32'h00A00093) $display("FAIL hold_instr cycle %0d got %h want 00a00093", k, ins0); else passed++;
      checks++; if (pc0 !== 32'h200) $display("FAIL hold_pc cycle %0d got %h want 200", k, pc0); else passed++;
      checks++; if (ins1 !== word(32'h200)) $display("FAIL hold_instr1 cycle %0d got %h want %h", k, ins1, word(32'h200)); else passed++;
      tick();
    end
    checks++; if (cnt0 !== 16'd3) $display("FAIL hold_cnt got %0d want 3", cnt0); else passed++;
    instr0 = word(32'h204);
    #1;
    checks++; if (pc0 !== 32'h204) $display("FAIL release_pc got %h want 204", pc0); else passed++;
    checks++; if (ins0 !== word(32'h204)) $display("FAIL release_instr got %h want %h", ins0, word(32'h204)); else passed++;
    checks++; if (v0 !== 1'b1) $display("FAIL release_valid got %0b want 1", v0); else passed++;
  endtask

  task automatic test_flush();
    stall = 1'b0; flush = 1'b0; if_valid = 1'b1;
    if_pc = 32'h300; instr1 = word(32'h300);
    tick();
    stall = 1'b1; instr0 = 32'h11111111;
    #1;
    tick();
    flush = 1'b1; instr0 = 32'h22222222;
    #1;
    tick();
    flush = 1'b0; stall = 1'b0; if_pc = 32'h304; instr1 = word(32'h304);
    #1;
    checks++; if (v0 !== 1'b0) $display("FAIL flush_valid got %0b want 0", v0); else passed++;
    checks++; if (ins0 !== NOP) $display("FAIL flush_instr0 got %h want %h", ins0, NOP); else passed++;
    checks++; if (ins1 !== NOP) $display("FAIL flush_instr1 got %h want %h", ins1, NOP); else passed++;
    checks++; if (cnt0 !== 16'd4) $display("FAIL flush_cnt got %0d want 4", cnt0); else passed++;
    checks++; if (pc0 !== 32'h300) $display("FAIL flush_pc_hold got %h want 300", pc0); else passed++;
    tick();
    instr0 = 32'h33333333;
    #1;
    checks++; if (ins0 !== 32'h33333333) $display("FAIL flush_pass_instr got %h want 33333333", ins0); else passed++;
    checks++; if (pc0 !== 32'h304) $display("FAIL flush_reload_pc got %h want 304", pc0); else passed++;
    checks++; if (ins1 !== word(32'h304)) $display("FAIL flush_reload_instr1 got %h want %h", ins1, word(32'h304)); else passed++;
  endtask

  task automatic test_bubble_wrap();
    stall = 1'b0; flush = 1'b0; if_valid = 1'b0;
    if_pc = 32'hFFFFFFFC; instr1 = 32'h12345678;
    tick();
    if_valid = 1'b1; if_pc = 32'h0; instr0 = 32'h87654321;
    #1;
    checks++; if (v0 !== 1'b0) $display("FAIL bubble_valid got %0b want 0", v0); else passed++;
    checks++; if (ins0 !== NOP) $display("FAIL bubble_instr0 got %h want %h", ins0, NOP); else passed++;
    checks++; if (ins1 !== NOP) $display("FAIL bubble_instr1 got %h want %h", ins1, NOP); else passed++;
    checks++; if (pc0 !== 32'hFFFFFFFC) $display("FAIL bubble_pc got %h want fffffffc", pc0); else passed++;
    checks++; if (pc40 !== 32'h0) $display("FAIL wrap_pc4_0 got %h want 0", pc40); else passed++;
    checks++; if (pc41 !== 32'h0) $display("FAIL wrap_pc4_1 got %h want 0", pc41); else passed++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      stall    = ($urandom_range(0, 9) < 4);
      flush    = ($urandom_range(0, 9) < 2);
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {$urandom(), 2'b00} >> 0;
      if_pc[1:0] = 2'b00;
      instr0   = $urandom();
      instr1   = $urandom();
      #1;
      checks++; if (v0 !== m_valid) $display("FAIL rnd_valid0 got %0b want %0b", v0, m_valid); else passed++;
      checks++; if (pc0 !== m_pc) $display("FAIL rnd_pc0 got %h want %h", pc0, m_pc); else passed++;
      checks++; if (pc40 !== m_pc + 32'd4) $display("FAIL rnd_pc4_0 got %h want %h", pc40, m_pc + 32'd4); else passed++;
      checks++; if (ins0 !== exp_ins0()) $display("FAIL rnd_instr0 got %h want %h", ins0, exp_ins0()); else passed++;
      checks++; if (v1 !== m_valid) $display("FAIL rnd_valid1 got %0b want %0b", v1, m_valid); else passed++;
      checks++; if (pc41 !== m_pc + 32'd4) $display("FAIL rnd_pc4_1 got %h want %h", pc41, m_pc + 32'd4); else passed++;
      checks++; if (ins1 !== exp_ins1()) $display("FAIL rnd_instr1 got %h want %h", ins1, exp_ins1()); else passed++;
      checks++; if (cnt1 !== exp_cnt16()) $display("FAIL rnd_cnt got %0d want %0d", cnt1, exp_cnt16()); else passed++;
      checks++; if (cnts !== exp_cnt4()) $display("FAIL rnd_cnt4 got %0d want %0d", cnts, exp_cnt4()); else passed++;
      tick();
    end
  endtask

  task automatic test_saturation();
    stall = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1; stall = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (cnts !== ((k > 15) ? 4'hF : 4'(k))) $display("FAIL sat_cnt4 edge %0d got %0d want %0d", k, cnts, (k > 15) ? 15 : k);
      else passed++;
    end
    checks++; if (cnt0 !== 16'd20) $display("FAIL sat_cnt16 got %0d want 20", cnt0); else passed++;
    stall = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; if_valid = 1'b0;
    if_pc = 32'h0; instr0 = 32'h0; instr1 = 32'h0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_streaming();
    test_stall_hold();
    test_flush();
    test_bubble_wrap();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
